// File: rtl/register_file.sv
// Two-read/one-write register file (index 0 hardwired to zero) with a
// handshaked sequential readout port. Optional macro: REGFILE_WRITE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_dump_data;
    logic [ADDR_WIDTH-1:0] w_load_idx;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load;
    logic                  w_wr_en;

    assign w_wr_en = we && (waddr != '0);

    // Shared by both read ports and the readout snapshot load.
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] idx);
        if (idx == '0) begin
            return '0;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_en && (waddr == idx)) begin
            return wdata;
        end
`endif
        return r_regs[idx];
    endfunction

    assign rdata_a = read_reg(raddr_a);
    assign rdata_b = read_reg(raddr_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_idx   = r_idx + ADDR_WIDTH'(1);
        case (r_state)
            IDLE: begin
                if (dump_start) begin
                    w_state_next = SEND;
                    w_load       = 1'b1;
                    w_load_idx   = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_load_data = read_reg(w_load_idx);

    // Snapshot: dump_data only changes on a load, so later writes to the
    // index under backpressure do not disturb the pending beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_dump_data <= '0;
        end else if (w_load) begin
            r_idx       <= w_load_idx;
            r_dump_data <= w_load_data;
        end
    end

    assign dump_valid = (r_state == SEND);
    assign dump_busy  = (r_state != IDLE);
    assign dump_done  = (r_state == DONE);
    assign dump_addr  = r_idx;
    assign dump_data  = r_dump_data;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 32x32 geometry).
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int          n_checks;
    int          n_fail;
    logic [31:0] mdl [32];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after each rising edge, checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = 5'd3; raddr_b = 5'd9;
        dump_start = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        step();
        step();
        #1;
        n_checks++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/busy/done=%b%b%b addr=%0d data=%h, required 000/0/0",
                     dump_valid, dump_busy, dump_done, dump_addr, dump_data);
        end
        n_checks++;
        if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_read: rdata_a=%h rdata_b=%h, required 0", rdata_a, rdata_b);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEADBEEF);
        raddr_a = 5'd5;
        #1;
        n_checks++;
        if (rdata_a !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read_5: rdata_a=%h, required deadbeef", rdata_a);
        end
        write_reg(5'd0, 32'h00001234);
        raddr_b = 5'd0;
        #1;
        n_checks++;
        if (rdata_b !== 32'd0) begin
            n_fail++;
            $display("FAIL write_idx0: rdata_b=%h, required 0", rdata_b);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'd0;
`endif
        n_checks++;
        if (rdata_a !== exp_same) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rdata_a=%h, required %h", rdata_a, exp_same);
        end
        step();
        we = 1'b0;
        mdl[7] = 32'hA5A5A5A5;
        #1;
        n_checks++;
        if (rdata_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: rdata_a=%h, required a5a5a5a5", rdata_a);
        end
    endtask

    task automatic test_readout();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 3));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            #1;
            n_checks++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_addr !== 5'(b) || dump_data !== 32'(b * 3)) begin
                n_fail++;
                $display("FAIL readout_beat%0d: valid=%b busy=%b addr=%0d data=%0d, required 1 1 %0d %0d",
                         b, dump_valid, dump_busy, dump_addr, dump_data, b, b * 3);
            end
            step();
        end
        #1;
        n_checks++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL readout_done: done=%b valid=%b busy=%b, required 1 0 1", dump_done, dump_valid, dump_busy);
        end
        step();
        #1;
        n_checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL readout_idle: done=%b busy=%b, required 0 0", dump_done, dump_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            exp = mdl[b];
            #1;
            n_checks++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'(b) || dump_data !== exp) begin
                n_fail++;
                $display("FAIL bp_beat%0d: valid=%b addr=%0d data=%h, required 1 %0d %h",
                         b, dump_valid, dump_addr, dump_data, b, exp);
            end
            if (b == 10) begin
                dump_ready = 1'b0;
                we = 1'b1; waddr = 5'd10; wdata = 32'h0000FFFF;
                for (int s = 0; s < 4; s++) begin
                    step();
                    #1;
                    n_checks++;
                    if (dump_valid !== 1'b1 || dump_addr !== 5'd10 || dump_data !== 32'd30) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: valid=%b addr=%0d data=%h, required 1 10 0000001e",
                                 s, dump_valid, dump_addr, dump_data);
                    end
                end
                we = 1'b0;
                mdl[10] = 32'h0000FFFF;
                dump_ready = 1'b1;
            end
            step();
        end
        #1;
        n_checks++;
        if (dump_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: done=%b, required 1", dump_done);
        end
        step();
    endtask

    task automatic test_ignored_start();
        int done_cnt;
        done_cnt = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            dump_start = (b == 5) || (b == 6);
            #1;
            n_checks++;
            if (dump_addr !== 5'(b) || dump_data !== mdl[b]) begin
                n_fail++;
                $display("FAIL ign_beat%0d: addr=%0d data=%h, required %0d %h", b, dump_addr, dump_data, b, mdl[b]);
            end
            step();
        end
        dump_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (dump_done === 1'b1) done_cnt++;
            step();
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL ign_done_count: pulses=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        done_cnt = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 32; c++) step();
        #1;
        n_checks++;
        if (dump_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%b, required 1", dump_done);
        end
        step();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        #1;
        n_checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: valid=%b addr=%0d data=%h, required 1 0 0", dump_valid, dump_addr, dump_data);
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dump_done === 1'b1) done_cnt++;
            step();
        end
        n_checks++;
        if (done_cnt != 1 || dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done: pulses=%0d busy=%b, required 1 0", done_cnt, dump_busy);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        done_cnt = 0;
        raddr_a = 5'd12;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 12; c++) step();
        #1;
        n_checks++;
        if (dump_addr !== 5'd12 || dump_data !== 32'd36) begin
            n_fail++;
            $display("FAIL abort_at12: addr=%0d data=%0d, required 12 36", dump_addr, dump_data);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0 || rdata_a !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: vbd=%b%b%b addr=%0d data=%h rdata_a=%h, required all 0",
                     dump_valid, dump_busy, dump_done, dump_addr, dump_data, rdata_a);
        end
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dump_done === 1'b1) done_cnt++;
        end
        reset = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        #1;
        n_checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd0 || rdata_a !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_restart: valid=%b addr=%0d rdata_a(12)=%h, required 1 0 0", dump_valid, dump_addr, rdata_a);
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dump_done === 1'b1) done_cnt++;
            if (dump_valid === 1'b1 && dump_data !== 32'd0) begin
                n_checks++;
                n_fail++;
                $display("FAIL abort_zero_data: addr=%0d data=%h, required 0", dump_addr, dump_data);
            end
            step();
        end
        n_checks++;
        if (done_cnt != 1 || dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done_count: pulses=%0d busy=%b, required 1 0", done_cnt, dump_busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_readout();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: index width; depth = 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports we  in  1 (write enable), waddr  in  ADDR_WIDTH (write index), wdata  in  DATA_WIDTH (write data).
REQ-006 SHALL have ports raddr_a, raddr_b  in  ADDR_WIDTH (read indices) and rdata_a, rdata_b  out  DATA_WIDTH (read data).
REQ-007 SHALL have port dump_start  in  1: request a full sequential readout.
REQ-008 SHALL have ports dump_valid  out  1, dump_ready  in  1, dump_addr  out  ADDR_WIDTH, dump_data  out  DATA_WIDTH: readout beat handshake.
REQ-009 SHALL have ports dump_busy  out  1 (readout in progress) and dump_done  out  1 (one-cycle completion pulse).

Function
REQ-010 SHALL write wdata into register waddr at posedge clk when we=1 and waddr!=0.
REQ-011 SHALL hardwire register 0 to zero; writes to index 0 are discarded.
REQ-012 SHALL drive rdata_a/rdata_b combinationally from the indexed register, with zero latency; index 0 reads 0.
REQ-013 SHALL implement the readout FSM with states IDLE, SEND, DONE.
REQ-014 In IDLE with dump_start=1, the FSM SHALL go to SEND, set the beat index to 0, and load dump_data with register 0.
REQ-015 In SEND, the FSM SHALL assert dump_valid=1, dump_busy=1, and dump_addr=beat index.
REQ-016 A beat SHALL be accepted on a posedge with dump_valid=1 and dump_ready=1.
REQ-017 While dump_valid=1 and dump_ready=0, dump_addr and dump_data SHALL hold stable, including across writes to that index (snapshot semantics).
REQ-018 On an accepted beat with index < depth-1, the FSM SHALL increment the index and load dump_data from the next register in the same edge.
REQ-019 On an accepted beat with index = depth-1, the FSM SHALL go to DONE; in DONE, dump_done=1 and dump_valid=0 for exactly one cycle, then the FSM returns to IDLE.
REQ-020 dump_start SHALL be ignored outside IDLE; register writes and read ports SHALL operate normally during readout.
REQ-021 dump_busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-022 Back-to-back readout: dump_start=1 in the cycle after DONE SHALL start a new readout.

Reset
REQ-023 reset=0 SHALL immediately, without a clock, clear all registers to 0 and force the FSM to IDLE with beat index 0.
REQ-024 During reset, dump_valid, dump_busy, dump_done, dump_addr and dump_data SHALL be 0; rdata_a/rdata_b SHALL read 0.
REQ-025 Reset asserted mid-readout SHALL abort the readout with no dump_done pulse.
REQ-026 Reset deassertion SHALL take effect at the following posedge clk; dump_start sampled at that edge SHALL be honoured.

Configuration
REQ-027 Macro REGFILE_WRITE_BYPASS_EN defined: when we=1, waddr!=0 and a read index equals waddr, rdata_a/rdata_b SHALL return wdata combinationally in the same cycle.
REQ-028 With REGFILE_WRITE_BYPASS_EN defined, a readout load (REQ-014/REQ-018) coinciding with a write to the loaded index SHALL capture wdata.
REQ-029 Macro REGFILE_WRITE_BYPASS_EN undefined: read ports and readout loads SHALL return the pre-write register value; new data SHALL be visible from the next cycle.

Verification
REQ-030 Write/read scenario: reset, then write 0xDEADBEEF to index 5; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; write 0x1234 to index 0 -> raddr_b=0 reads 0.
REQ-031 Bypass scenario: we=1, waddr=7, wdata=0xA5A5A5A5, raddr_a=7 in the same cycle -> rdata_a=0xA5A5A5A5 with REGFILE_WRITE_BYPASS_EN, old value 0 without it.
REQ-032 Readout scenario: preload reg[i]=i*3, pulse dump_start with dump_ready=1 -> 32 consecutive beats (addr 0..31, data 0,3,...,93), then one dump_done pulse, then dump_busy=0.
REQ-033 Backpressure scenario: during readout hold dump_ready=0 at addr 10 for 4 cycles while writing 0xFFFF to index 10 -> dump_data stays 30; the beat resumes on ready=1.
REQ-034 Reset-abort scenario: assert reset=0 mid-clock at beat 12 -> all outputs 0 immediately, no dump_done; after release, reg[12] reads 0 and a new dump_start works.
REQ-035 Ignored-start scenario: pulse dump_start during SEND -> no restart, beat order unchanged, exactly one dump_done pulse.
